xbar_mem_slave: RTL and testbench
=================================

Name: xbar_mem_slave

Overview:
- Word-addressed memory endpoint on the slave side of the crossbar, sitting directly downstream of a crossbar slave port.
- Consumes req/addr/cmd/wdata and returns ack, then rdata/resp for reads.
- Configurable wait states before ack and fixed read latency, so crossbar arbitration and response ordering can be exercised against a realistic target.

Parameters:
- ADDR_WIDTH, 32, address width; matches the crossbar interface package.
- DATA_WIDTH, 32, data width; matches the crossbar interface package.
- MEM_DEPTH, 256, number of DATA_WIDTH words; power of two, at least 2.
- WAIT_STATES, 0, cycles req must be held before ack; range 0..15.
- READ_LATENCY, 2, cycles from read accept edge to resp; range 1..8.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req  input  1  request valid from crossbar
- addr  input  ADDR_WIDTH  byte address
- cmd  input  1  0 = read, 1 = write
- wdata  input  DATA_WIDTH  write data
- ack  output  1  request accepted this cycle
- rdata  output  DATA_WIDTH  read data, valid only while resp = 1
- resp  output  1  one-cycle read-response strobe

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ack = 0, resp = 0, rdata = 0. FSM goes to IDLE, wait counter = 0, all read-pipeline valid bits cleared.
- Memory contents are not reset.
- Word index = addr[2 +: log2(MEM_DEPTH)]. addr[1:0] and upper bits are ignored, so addresses alias modulo MEM_DEPTH*4.
- Accept: a transfer is accepted on a rising edge where req = 1 and ack = 1. addr, cmd and wdata are sampled only on that edge.
- ack is combinational from FSM state and req. It is 0 whenever rst = 1.
- FSM has two states, IDLE and WAIT:
  - WAIT_STATES = 0: in IDLE, ack = req. Back-to-back accepts every cycle are allowed. WAIT is never entered.
  - WAIT_STATES > 0, IDLE with req = 1: go to WAIT with counter = 1, ack = 0.
  - In WAIT with req = 1 and counter < WAIT_STATES: counter++, ack = 0.
  - In WAIT with req = 1 and counter == WAIT_STATES: ack = 1, accept, go to IDLE, counter = 0.
  - Net timing: req first seen in cycle 0 → ack in cycle WAIT_STATES. Each new request pays the full wait again.
  - In WAIT with req = 0 (request withdrawn): go to IDLE, counter = 0. No access happens.
- Write accept: mem[index] is updated on the accept edge. No resp is generated.
- Read accept:
  - The memory word is captured on the accept edge. It reflects every write accepted on earlier edges, so read-after-write on consecutive cycles returns the new data.
  - The captured word enters a READ_LATENCY-stage shift pipeline (valid bit + data).
  - Read accepted on edge N → resp = 1 and rdata = word during the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles after the accept cycle.
- Responses are in order, one per read, with no backpressure. The pipeline can hold READ_LATENCY reads in flight, which is the maximum possible.
- rdata = 0 whenever resp = 0.
- Reset mid-operation: in-flight reads are discarded with no resp. A pending WAIT is abandoned. A write on the same edge as rst = 1 is not performed.
- Unknown cmd (X) on an accept edge is a protocol error. An assertion fires in simulation.

Test Plan:
1. Reset: hold rst 3 cycles while req = 1 → ack = 0, resp = 0, rdata = 0 throughout. First ack appears only after rst falls.
2. WAIT_STATES=0, READ_LATENCY=2: write 0xDEADBEEF to 0x10 (ack the same cycle), read 0x10 in the next cycle → resp = 1 with rdata = 0xDEADBEEF exactly 2 cycles after the read accept cycle; resp = 0 otherwise.
3. Back-to-back: write 0x11/0x22/0x33/0x44 to 0x0/0x4/0x8/0xC, then 4 consecutive read cycles → 4 consecutive resp cycles in order returning 0x11, 0x22, 0x33, 0x44.
4. WAIT_STATES=3: req held from cycle 0 → ack only in cycle 3. Second case: req dropped after 2 cycles → no ack, target word unchanged (verified by a later read).
5. Aliasing with MEM_DEPTH=256: write 0xA5A5A5A5 to 0x400, read 0x000 and 0x003 → both return 0xA5A5A5A5.
6. Reset with reads in flight (READ_LATENCY=4): accept 2 reads, assert rst 1 cycle later → no resp ever issued for them; the next read after reset behaves normally.

Source files
------------

// File: rtl/xbar_mem_slave.sv
// Word-addressed memory target for a crossbar slave port: configurable wait
// states before ack, fixed-latency in-order read responses, no backpressure.
module xbar_mem_slave #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_DEPTH    = 256,
   parameter int WAIT_STATES  = 0,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  cmd,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  resp
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t                  state, state_next;
   logic [3:0]              cnt, cnt_next;
   logic                    accept, rd_acc, wr_acc;
   logic [IDX_W-1:0]        idx;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_vld;
   logic                    unused_addr;

   // Byte address in, word index out; the remaining bits alias.
   assign idx         = addr[2 +: IDX_W];
   assign unused_addr = ^{addr[ADDR_WIDTH-1:IDX_W+2], addr[1:0]};

   assign accept = req & ack;
   assign rd_acc = accept & ~cmd;
   assign wr_acc = accept & cmd;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      ack        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (WAIT_STATES == 0) begin
               ack = req;
            end else if (req) begin
               state_next = ST_WAIT;
               cnt_next   = 4'd1;
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_next = ST_IDLE;
               cnt_next   = 4'd0;
            end else if (cnt < WS) begin
               cnt_next = cnt + 4'd1;
            end else begin
               ack        = 1'b1;
               state_next = ST_IDLE;
               cnt_next   = 4'd0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = 4'd0;
         end
      endcase
      if (rst) ack = 1'b0;
   end

   // Memory and pipeline data carry no reset; only the valid bits do.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) mem[idx] <= wdata;
      if (rd_acc) pipe_data[0] <= mem[idx];
      for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= rd_acc;
         for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   assign resp  = pipe_vld[READ_LATENCY-1];
   assign rdata = resp ? pipe_data[READ_LATENCY-1] : '0;

   always_ff @(posedge clk) begin
      if (!rst && accept) assert (!$isunknown(cmd));
   end

endmodule

// File: tb/tb_xbar_mem_slave.sv
// Directed bench for xbar_mem_slave: three instances cover zero-wait/latency-2,
// three-wait-state and latency-4 configurations.
module tb_xbar_mem_slave;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        cmd;
   logic [31:0] wdata;
   logic        req_a, req_b, req_c;
   logic        ack_a, ack_b, ack_c;
   logic        resp_a, resp_b, resp_c;
   logic [31:0] rdata_a, rdata_b, rdata_c;

   int checks = 0;
   int errors = 0;

   xbar_mem_slave #(.WAIT_STATES(0), .READ_LATENCY(2)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .addr(addr), .cmd(cmd), .wdata(wdata),
      .ack(ack_a), .rdata(rdata_a), .resp(resp_a));

   xbar_mem_slave #(.WAIT_STATES(3), .READ_LATENCY(2)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .addr(addr), .cmd(cmd), .wdata(wdata),
      .ack(ack_b), .rdata(rdata_b), .resp(resp_b));

   xbar_mem_slave #(.WAIT_STATES(0), .READ_LATENCY(4)) dut_c (
      .clk(clk), .rst(rst), .req(req_c), .addr(addr), .cmd(cmd), .wdata(wdata),
      .ack(ack_c), .rdata(rdata_c), .resp(resp_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_a = 1'b1; req_b = 1'b0; req_c = 1'b0;
      addr = 32'h0; cmd = 1'b0; wdata = 32'h0;
      tick();
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (ack_a !== 1'b0 || resp_a !== 1'b0 || rdata_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs cyc %0d: ack=%b resp=%b rdata=%h, required 0/0/0",
                     c, ack_a, resp_a, rdata_a);
         end
         tick();
      end
      rst = 1'b0;
      #1;
      checks++;
      if (ack_a !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_ack: ack=%b, required 1", ack_a);
      end
      req_a = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      req_a = 1'b1; cmd = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (ack_a !== 1'b1 || resp_a !== 1'b0) begin
         errors++;
         $display("FAIL wr_ack: ack=%b resp=%b, required 1/0", ack_a, resp_a);
      end
      tick();
      cmd = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) req_a = 1'b0;
         #1;
         if (c == 0) begin
            checks++;
            if (ack_a !== 1'b1) begin
               errors++;
               $display("FAIL rd_ack: ack=%b, required 1", ack_a);
            end
         end
         checks++;
         if (resp_a !== (c == 2) || rdata_a !== ((c == 2) ? 32'hDEADBEEF : 32'h0)) begin
            errors++;
            $display("FAIL raw_resp cyc %0d: resp=%b rdata=%h, required %b/%h", c, resp_a,
                     rdata_a, (c == 2), ((c == 2) ? 32'hDEADBEEF : 32'h0));
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d [4];
      exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
      for (int i = 0; i < 4; i++) begin
         req_a = 1'b1; cmd = 1'b1; addr = 32'(4 * i); wdata = exp_d[i];
         #1;
         checks++;
         if (ack_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wr_ack %0d: ack=%b, required 1", i, ack_a);
         end
         tick();
      end
      cmd = 1'b0;
      for (int c = 0; c < 7; c++) begin
         req_a = (c < 4);
         addr  = 32'(4 * c);
         #1;
         checks++;
         if (resp_a !== (c >= 2 && c < 6) ||
             rdata_a !== ((c >= 2 && c < 6) ? exp_d[(c + 2) % 4] : 32'h0)) begin
            errors++;
            $display("FAIL b2b_resp cyc %0d: resp=%b rdata=%h", c, resp_a, rdata_a);
         end
         tick();
      end
   endtask

   task automatic test_wait_states();
      cmd = 1'b1; addr = 32'h20; wdata = 32'h77;
      for (int c = 0; c < 4; c++) begin
         req_b = 1'b1;
         #1;
         checks++;
         if (ack_b !== (c == 3)) begin
            errors++;
            $display("FAIL wait_ack cyc %0d: ack=%b, required %b", c, ack_b, (c == 3));
         end
         tick();
      end
      req_b = 1'b0;
      tick();
      wdata = 32'h99;
      for (int c = 0; c < 3; c++) begin
         req_b = (c < 2);
         #1;
         checks++;
         if (ack_b !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_ack cyc %0d: ack=%b, required 0", c, ack_b);
         end
         tick();
      end
      cmd = 1'b0;
      for (int c = 0; c < 7; c++) begin
         req_b = (c < 4);
         #1;
         checks++;
         if (ack_b !== (c == 3) || resp_b !== (c == 5) ||
             rdata_b !== ((c == 5) ? 32'h77 : 32'h0)) begin
            errors++;
            $display("FAIL withdraw_read cyc %0d: ack=%b resp=%b rdata=%h, required %b/%b/%h",
                     c, ack_b, resp_b, rdata_b, (c == 3), (c == 5),
                     ((c == 5) ? 32'h77 : 32'h0));
         end
         tick();
      end
   endtask

   task automatic test_alias();
      req_a = 1'b1; cmd = 1'b1; addr = 32'h400; wdata = 32'hA5A5A5A5;
      tick();
      cmd = 1'b0;
      for (int c = 1; c < 6; c++) begin
         req_a = (c < 3);
         addr  = (c == 1) ? 32'h0 : 32'h3;
         #1;
         checks++;
         if (resp_a !== (c == 3 || c == 4) ||
             rdata_a !== ((c == 3 || c == 4) ? 32'hA5A5A5A5 : 32'h0)) begin
            errors++;
            $display("FAIL alias_resp cyc %0d: resp=%b rdata=%h", c, resp_a, rdata_a);
         end
         tick();
      end
   endtask

   task automatic test_reset_inflight();
      req_c = 1'b1; cmd = 1'b1; addr = 32'h8; wdata = 32'h12345678;
      tick();
      cmd = 1'b0;
      tick();
      tick();
      req_c = 1'b0; rst = 1'b1;
      #1;
      checks++;
      if (ack_c !== 1'b0) begin
         errors++;
         $display("FAIL rst_ack: ack=%b, required 0", ack_c);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++;
         if (resp_c !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush cyc %0d: resp=%b, required 0", c, resp_c);
         end
         tick();
      end
      for (int c = 0; c < 6; c++) begin
         req_c = (c == 0);
         #1;
         checks++;
         if (resp_c !== (c == 4) || rdata_c !== ((c == 4) ? 32'h12345678 : 32'h0)) begin
            errors++;
            $display("FAIL rst_after_read cyc %0d: resp=%b rdata=%h, required %b", c, resp_c,
                     rdata_c, (c == 4));
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_wait_states();
      test_alias();
      test_reset_inflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
